tlul_tempsensor_host: RTL and testbench
=======================================

Name: tlul_tempsensor_host

Overview:
- TL-UL initiator that drives the temperature-sensor register block over a single TL-UL port.
- Per conversion it:
  - pulses the counter reset (0x04),
  - programs conversion time (0x08),
  - enables the sensor (0x0C),
  - polls DONE (0x18),
  - reads DOUT (0x14),
  - disables the sensor.
- Delivers the 24-bit result on a valid/ready stream. Sits between a local controller (e.g. thermal manager) and the sensor's TL-UL device port.

Parameters:
- BaseAddr, 32'h0, base address of sensor registers; added to every offset.
- SourceId, 0, value driven on a_source.
- PollGap, 16, idle cycles between consecutive DONE reads (>=1).
- MaxPolls, 1024, DONE reads returning 0 before timeout (>=1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  request one conversion; sampled only in IDLE
- conv_time_i  in  4  SEL_CONV_TIME value; latched when start accepted
- busy_o  out  1  high in every state except IDLE
- sample_o  out  24  conversion result (DOUT[23:0])
- sample_valid_o  out  1  result valid
- sample_ready_i  in  1  consumer accepts result
- err_o  out  1  one-cycle pulse on bus error or poll timeout
- tl_o  out  tl_h2d_t  TL-UL request channel (A) plus d_ready
- tl_i  in  tl_d2h_t  TL-UL response channel (D) plus a_ready

Behaviour:
- Reset (rst_i high at posedge): FSM=IDLE; all counters 0; busy_o=0, sample_valid_o=0, sample_o=0, err_o=0; tl_o.a_valid=0, tl_o.d_ready=0. Reset mid-transaction abandons it; nothing is re-issued.
- Bus op (all states that issue one):
  - at most one outstanding;
  - a_valid held with stable fields until a_valid&a_ready;
  - then a_valid=0, d_ready=1 until d_valid;
  - a_size=2, a_mask=4'hF, a_source=SourceId, a_param=0, a_user=default, address word-aligned;
  - writes use PutFullData, reads use Get.
- All outputs are registered. a_valid rises the cycle after a state is entered.
- FSM:
  - IDLE: start_i=1 → latch conv_time_i, go to RST_LO.
  - RST_LO: write 0x04=0 → RST_HI.
  - RST_HI: write 0x04=1 → TIME.
  - TIME: write 0x08={28'b0,conv_time} → EN.
  - EN: write 0x0C=1 → POLL; poll counter cleared.
  - POLL: read 0x18.
    - d_data[0]=1 → DOUT.
    - else increment poll counter; if it reaches MaxPolls → ABORT, else → GAP.
  - GAP: count PollGap cycles → POLL.
  - DOUT: read 0x14; capture d_data[23:0] into sample_o → DIS.
  - DIS: write 0x0C=0 → OUT.
  - OUT: sample_valid_o=1; sample_o stable until sample_valid_o&sample_ready_i, then sample_valid_o=0 → IDLE.
  - ABORT: write 0x0C=0 (d_error ignored) → IDLE, pulsing err_o for one cycle on exit.
- d_error=1 on any response other than in ABORT: discard the response, go to ABORT. A sample_o captured earlier is never marked valid.
- Boundary rules:
  - start_i outside IDLE is ignored.
  - sample_ready_i outside OUT is ignored.
  - A response opcode mismatch (AccessAck vs AccessAckData) is treated as d_error.
  - Counters saturate; no wrap.

Optional Feature:
- Macro TEMPSENS_HOST_CONT_EN.
- Defined: on the OUT handshake, if start_i=1 that cycle, the FSM goes directly to RST_LO reusing the latched conv_time. busy_o stays high, with no IDLE cycle.
- Undefined: OUT always returns to IDLE; a new start_i is required in IDLE.

Test Plan:
- start_i=1, conv_time_i=4'h5; responder returns DONE=0 twice then 1, DOUT=24'hABCDEF → write sequence 0x04=0, 0x04=1, 0x08=5, 0x0C=1; three 0x18 reads, each pair separated by ≥16 idle cycles; 0x14 read; 0x0C=0; sample_o=24'hABCDEF with valid; err_o never set.
- Responder holds a_ready=0 for 10 cycles on the 0x08 write → a_valid, address and data held stable for all 11 cycles; no other request issued.
- DONE never 1, MaxPolls=4 → exactly 4 reads of 0x18, then 0x0C=0; err_o pulses once; sample_valid_o stays 0; busy_o=0 afterwards.
- d_error=1 on the 0x14 read → next request is 0x0C=0; err_o pulse; no sample_valid_o.
- sample_ready_i=0 for 20 cycles in OUT → sample_valid_o and sample_o stable; start_i pulses ignored. rst_i asserted during a POLL read → next cycle a_valid=0, busy_o=0.
- With TEMPSENS_HOST_CONT_EN and start_i held 1: after the first handshake the next request is the 0x04=0 write and busy_o never drops. Without the macro: busy_o=0 for ≥1 cycle between conversions.

Source files
------------

// File: rtl/tlul_tempsensor_host_if.sv
// TL-UL link types and the host-side port bundle for the temperature-sensor host.
// The package carries the packed A/D channel structs and opcode constants.
// The interface groups both directions; master drives A + d_ready, slave drives D + a_ready.
package tlul_tempsensor_host_pkg;

  localparam logic [2:0] OP_PUT_FULL  = 3'd0;
  localparam logic [2:0] OP_GET       = 3'd4;
  localparam logic [2:0] OP_ACK       = 3'd0;
  localparam logic [2:0] OP_ACK_DATA  = 3'd1;
  localparam logic [15:0] A_USER_DEFAULT = 16'h0;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

interface tlul_tempsensor_host_if;
  import tlul_tempsensor_host_pkg::*;

  tl_h2d_t tl_o;
  tl_d2h_t tl_i;

  modport master (output tl_o, input tl_i);
  modport slave  (input tl_o, output tl_i);
endinterface

// File: rtl/tlul_tempsensor_host.sv
// TL-UL initiator sequencing one temperature conversion per start and streaming the 24-bit result.
// Latency: every bus op costs issue + A-accept + D-return cycles; DONE polls are spaced PollGap cycles apart.
// Backpressure: one outstanding op, a_valid held until a_ready; result held on sample_valid_o until sample_ready_i.
// Optional macro TEMPSENS_HOST_CONT_EN: start_i high on the result handshake chains straight into a new conversion.
module tlul_tempsensor_host
  import tlul_tempsensor_host_pkg::*;
#(
  parameter logic [31:0] BaseAddr = 32'h0,
  parameter int unsigned SourceId = 0,
  parameter int unsigned PollGap  = 16,
  parameter int unsigned MaxPolls = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [3:0]  conv_time_i,
  output logic        busy_o,
  output logic [23:0] sample_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        err_o,
  tlul_tempsensor_host_if.master tl
);

  localparam int PW = $clog2(MaxPolls + 1);
  localparam int GW = $clog2(PollGap + 1);

  typedef enum logic [3:0] {
    IDLE, RST_LO, RST_HI, TIME, EN, POLL, GAP, DOUT, DIS, OUT, ABORT
  } state_t;

  // Sub-phase of a bus state: drive the request, wait for A accept, wait for D return.
  typedef enum logic [1:0] {PH_ISSUE, PH_REQ, PH_RSP} phase_t;

  state_t         state;
  phase_t         phase;
  logic [PW-1:0]  poll_cnt;
  logic [GW-1:0]  gap_cnt;
  logic [3:0]     conv_time_q;
  tl_h2d_t        h2d_q;

  logic [31:0]    req_off;
  logic           req_wr;
  logic [31:0]    req_wdata;
  logic [2:0]     exp_d_op;
  logic           rsp_bad;
  logic           unused_d2h;

  assign tl.tl_o = h2d_q;

  // Register offset, direction and write data of the op belonging to the current state.
  always_comb begin
    req_off   = 32'h0;
    req_wr    = 1'b1;
    req_wdata = 32'h0;
    case (state)
      RST_LO:     begin req_off = 32'h04; req_wdata = 32'h0; end
      RST_HI:     begin req_off = 32'h04; req_wdata = 32'h1; end
      TIME:       begin req_off = 32'h08; req_wdata = {28'b0, conv_time_q}; end
      EN:         begin req_off = 32'h0C; req_wdata = 32'h1; end
      POLL:       begin req_off = 32'h18; req_wr = 1'b0; end
      DOUT:       begin req_off = 32'h14; req_wr = 1'b0; end
      DIS, ABORT: begin req_off = 32'h0C; req_wdata = 32'h0; end
      default:    ;
    endcase
  end

  // A response is bad if flagged as error or if its opcode does not match the request kind.
  always_comb begin
    exp_d_op = (h2d_q.a_opcode == OP_GET) ? OP_ACK_DATA : OP_ACK;
    rsp_bad  = tl.tl_i.d_error || (tl.tl_i.d_opcode != exp_d_op);
  end

  assign unused_d2h = ^{tl.tl_i.d_param, tl.tl_i.d_size, tl.tl_i.d_source,
                        tl.tl_i.d_sink, tl.tl_i.d_user, tl.tl_i.d_data[31:24]};

  // Conversion sequencer: state, bus channel and all outputs are registered here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      phase          <= PH_ISSUE;
      poll_cnt       <= '0;
      gap_cnt        <= '0;
      conv_time_q    <= 4'h0;
      h2d_q          <= '0;
      busy_o         <= 1'b0;
      sample_o       <= 24'h0;
      sample_valid_o <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            conv_time_q <= conv_time_i;
            state       <= RST_LO;
            phase       <= PH_ISSUE;
            busy_o      <= 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt >= GW'(PollGap - 1)) begin
            gap_cnt <= '0;
            state   <= POLL;
            phase   <= PH_ISSUE;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        OUT: begin
          if (sample_ready_i) begin
            sample_valid_o <= 1'b0;
`ifdef TEMPSENS_HOST_CONT_EN
            if (start_i) begin
              state <= RST_LO;
              phase <= PH_ISSUE;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
`else
            state  <= IDLE;
            busy_o <= 1'b0;
`endif
          end
        end

        default: begin
          case (phase)
            PH_ISSUE: begin
              h2d_q.a_valid   <= 1'b1;
              h2d_q.a_opcode  <= req_wr ? OP_PUT_FULL : OP_GET;
              h2d_q.a_param   <= 3'd0;
              h2d_q.a_size    <= 2'd2;
              h2d_q.a_source  <= 8'(SourceId);
              h2d_q.a_address <= (BaseAddr + req_off) & 32'hFFFF_FFFC;
              h2d_q.a_mask    <= 4'hF;
              h2d_q.a_data    <= req_wdata;
              h2d_q.a_user    <= A_USER_DEFAULT;
              h2d_q.d_ready   <= 1'b0;
              phase           <= PH_REQ;
            end

            PH_REQ: begin
              if (tl.tl_i.a_ready) begin
                h2d_q.a_valid <= 1'b0;
                h2d_q.d_ready <= 1'b1;
                phase         <= PH_RSP;
              end
            end

            default: begin
              if (tl.tl_i.d_valid) begin
                h2d_q.d_ready <= 1'b0;
                phase         <= PH_ISSUE;
                if (state == ABORT) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  err_o  <= 1'b1;
                end else if (rsp_bad) begin
                  state <= ABORT;
                end else begin
                  case (state)
                    RST_LO: state <= RST_HI;
                    RST_HI: state <= TIME;
                    TIME:   state <= EN;
                    EN: begin
                      state    <= POLL;
                      poll_cnt <= '0;
                    end
                    POLL: begin
                      if (tl.tl_i.d_data[0]) begin
                        state <= DOUT;
                      end else begin
                        if (32'(poll_cnt) < MaxPolls) poll_cnt <= poll_cnt + PW'(1);
                        if (32'(poll_cnt) + 32'd1 >= MaxPolls) begin
                          state <= ABORT;
                        end else begin
                          state   <= GAP;
                          gap_cnt <= '0;
                        end
                      end
                    end
                    DOUT: begin
                      sample_o <= tl.tl_i.d_data[23:0];
                      state    <= DIS;
                    end
                    DIS: begin
                      state          <= OUT;
                      sample_valid_o <= 1'b1;
                    end
                    default: begin
                      state  <= IDLE;
                      busy_o <= 1'b0;
                    end
                  endcase
                end
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlul_tempsensor_host.sv
// Directed bench for tlul_tempsensor_host with a TL-UL register responder.
// The responder logs every accepted request and answers with scripted DONE/DOUT/error behaviour.
// Scenario tasks compare logged traffic and outputs against hand-computed values.
module tb_tlul_tempsensor_host;
  import tlul_tempsensor_host_pkg::*;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  conv_time;
  logic        busy;
  logic [23:0] sample;
  logic        sv;
  logic        ready;
  logic        err;

  tlul_tempsensor_host_if bus();

  tlul_tempsensor_host #(
    .BaseAddr(BASE), .SourceId(3), .PollGap(16), .MaxPolls(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .conv_time_i(conv_time),
    .busy_o(busy), .sample_o(sample), .sample_valid_o(sv),
    .sample_ready_i(ready), .err_o(err), .tl(bus.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // responder configuration
  int          done_after;
  logic [23:0] dout_val;
  bit          err_en;
  logic [31:0] err_addr;
  logic [31:0] stall_addr;
  int          stall_left;
  int          poll_seen;

  // request log
  logic [31:0] log_addr [64];
  logic [31:0] log_data [64];
  logic [2:0]  log_op   [64];
  logic [7:0]  log_src  [64];
  logic [3:0]  log_mask [64];
  logic [1:0]  log_size [64];
  int          log_hold [64];
  int          log_cyc  [64];
  bit          log_unst [64];
  int          log_n;

  // responder internals
  tl_h2d_t     snap;
  int          cur_hold;
  bit          cur_unst;
  bit          rsp_due;
  bit          d_hs;
  logic [2:0]  r_op;
  logic [31:0] r_data;
  logic        r_err;

  // monitors
  int err_cnt;
  bit sv_seen;
  int busy_low;

  always @(posedge clk) cyc <= cyc + 1;

  // TL-UL responder: decides D/A drives at the falling edge for the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      bus.tl_i = '0;
      rsp_due  = 0;
      d_hs     = 0;
      cur_hold = 0;
      cur_unst = 0;
    end else begin
      if (d_hs) begin
        bus.tl_i.d_valid = 1'b0;
        d_hs = 0;
      end
      if (rsp_due) begin
        bus.tl_i.d_valid  = 1'b1;
        bus.tl_i.d_opcode = r_op;
        bus.tl_i.d_data   = r_data;
        bus.tl_i.d_error  = r_err;
        bus.tl_i.d_source = 8'd3;
        rsp_due = 0;
      end
      if (bus.tl_i.d_valid && bus.tl_o.d_ready) d_hs = 1;
      if (bus.tl_o.a_valid) begin
        if (cur_hold == 0) snap = bus.tl_o;
        else if (bus.tl_o != snap) cur_unst = 1;
        cur_hold++;
        if (stall_left > 0 && bus.tl_o.a_address == stall_addr) begin
          stall_left--;
          bus.tl_i.a_ready = 1'b0;
        end else begin
          bus.tl_i.a_ready = 1'b1;
          if (log_n < 64) begin
            log_addr[log_n] = bus.tl_o.a_address;
            log_data[log_n] = bus.tl_o.a_data;
            log_op[log_n]   = bus.tl_o.a_opcode;
            log_src[log_n]  = bus.tl_o.a_source;
            log_mask[log_n] = bus.tl_o.a_mask;
            log_size[log_n] = bus.tl_o.a_size;
            log_hold[log_n] = cur_hold;
            log_cyc[log_n]  = cyc;
            log_unst[log_n] = cur_unst;
            log_n++;
          end
          if (bus.tl_o.a_opcode == OP_GET) begin
            r_op = OP_ACK_DATA;
            if (bus.tl_o.a_address == BASE + 32'h18) begin
              r_data = (poll_seen >= done_after) ? 32'h1 : 32'h0;
              poll_seen++;
            end else if (bus.tl_o.a_address == BASE + 32'h14) begin
              r_data = {8'h5A, dout_val};
            end else begin
              r_data = 32'h0;
            end
          end else begin
            r_op   = OP_ACK;
            r_data = 32'h0;
          end
          r_err    = err_en && (bus.tl_o.a_address == err_addr);
          rsp_due  = 1;
          cur_hold = 0;
          cur_unst = 0;
        end
      end else begin
        bus.tl_i.a_ready = 1'b0;
      end
    end
  end

  // Output monitors sampled at the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (err) err_cnt++;
      if (sv) sv_seen = 1;
      if (!busy) busy_low++;
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1; start = 0; ready = 0; conv_time = 4'h0;
    repeat (3) @(negedge clk);
    log_n = 0; poll_seen = 0; err_cnt = 0; sv_seen = 0; busy_low = 0;
    err_en = 0; stall_left = 0; stall_addr = 32'h0; err_addr = 32'h0;
    done_after = 0; dout_val = 24'h0;
    rst = 0;
  endtask

  task automatic pulse_start(input logic [3:0] ct);
    @(negedge clk);
    start = 1; conv_time = ct;
    @(negedge clk);
    start = 0; conv_time = 4'h0;
  endtask

  task automatic wait_sv(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sv) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
  endtask

  task automatic accept_sample();
    @(negedge clk);
    ready = 1;
    @(negedge clk);
    ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; start = 0; ready = 0; conv_time = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (sv !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", sv); end
    vectors++; if (sample !== 24'h0) begin miscompares++; $display("FAIL reset_sample got %h want 000000", sample); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (bus.tl_o.a_valid !== 1'b0) begin miscompares++; $display("FAIL reset_a_valid got %b want 0", bus.tl_o.a_valid); end
    vectors++; if (bus.tl_o.d_ready !== 1'b0) begin miscompares++; $display("FAIL reset_d_ready got %b want 0", bus.tl_o.d_ready); end
  endtask

  task automatic test_conversion();
    logic [31:0] eo [9];
    logic [31:0] ed [9];
    logic [2:0]  eop [9];
    bit ok;
    eo  = '{32'h04, 32'h04, 32'h08, 32'h0C, 32'h18, 32'h18, 32'h18, 32'h14, 32'h0C};
    ed  = '{32'h0, 32'h1, 32'h5, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    eop = '{OP_PUT_FULL, OP_PUT_FULL, OP_PUT_FULL, OP_PUT_FULL, OP_GET, OP_GET, OP_GET, OP_GET, OP_PUT_FULL};
    reset_dut();
    done_after = 2; dout_val = 24'hABCDEF;
    pulse_start(4'h5);
    wait_sv(3000, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL conv_done got timeout want sample_valid"); end
    vectors++; if (log_n !== 9) begin miscompares++; $display("FAIL conv_req_count got %0d want 9", log_n); end
    for (int i = 0; i < 9; i++) begin
      vectors++;
      if (log_addr[i] !== BASE + eo[i] || log_op[i] !== eop[i] || (eop[i] == OP_PUT_FULL && log_data[i] !== ed[i])) begin
        miscompares++;
        $display("FAIL conv_req%0d got addr %h op %0d data %h want addr %h op %0d data %h",
                 i, log_addr[i], log_op[i], log_data[i], BASE + eo[i], eop[i], ed[i]);
      end
    end
    vectors++; if (log_cyc[5] - log_cyc[4] < 17 || log_cyc[6] - log_cyc[5] < 17) begin
      miscompares++; $display("FAIL poll_gap got %0d,%0d cycles want >=17", log_cyc[5] - log_cyc[4], log_cyc[6] - log_cyc[5]); end
    vectors++; if (log_src[0] !== 8'd3 || log_size[0] !== 2'd2 || log_mask[0] !== 4'hF) begin
      miscompares++; $display("FAIL conv_fields got src %0d size %0d mask %h want 3 2 f", log_src[0], log_size[0], log_mask[0]); end
    vectors++; if (sample !== 24'hABCDEF) begin miscompares++; $display("FAIL conv_sample got %h want abcdef", sample); end
    vectors++; if (err_cnt !== 0) begin miscompares++; $display("FAIL conv_err got %0d pulses want 0", err_cnt); end
  endtask

  task automatic test_out_stall();
    int bad = 0;
    int n0 = log_n;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sv !== 1'b1 || sample !== 24'hABCDEF) bad++;
      start = i[0];
    end
    start = 0;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL out_hold got %0d unstable cycles want 0", bad); end
    vectors++; if (log_n !== n0) begin miscompares++; $display("FAIL out_start_ignored got %0d requests want %0d", log_n, n0); end
    accept_sample();
    vectors++; if (sv !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL out_accept got valid %b busy %b want 0 0", sv, busy); end
  endtask

  task automatic test_a_stall();
    bit ok;
    reset_dut();
    done_after = 0; dout_val = 24'h123456;
    stall_addr = BASE + 32'h08; stall_left = 10;
    pulse_start(4'hA);
    wait_sv(3000, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stall_done got timeout want sample_valid"); end
    vectors++; if (log_n !== 7) begin miscompares++; $display("FAIL stall_req_count got %0d want 7", log_n); end
    vectors++; if (log_addr[2] !== BASE + 32'h08 || log_hold[2] !== 11 || log_unst[2] !== 1'b0 || log_data[2] !== 32'hA) begin
      miscompares++; $display("FAIL stall_hold got addr %h hold %0d unstable %b data %h want %h 11 0 0000000a",
                              log_addr[2], log_hold[2], log_unst[2], log_data[2], BASE + 32'h08); end
    vectors++; if (sample !== 24'h123456) begin miscompares++; $display("FAIL stall_sample got %h want 123456", sample); end
    accept_sample();
  endtask

  task automatic test_timeout();
    bit ok;
    int polls = 0;
    reset_dut();
    done_after = 1000;
    pulse_start(4'h2);
    wait_idle(3000, ok);
    repeat (3) @(negedge clk);
    for (int i = 0; i < log_n; i++) if (log_addr[i] == BASE + 32'h18) polls++;
    vectors++; if (ok !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL timeout_idle got ok %b busy %b want 1 0", ok, busy); end
    vectors++; if (polls !== 4 || log_n !== 9) begin miscompares++; $display("FAIL timeout_polls got %0d polls %0d reqs want 4 9", polls, log_n); end
    vectors++; if (log_addr[8] !== BASE + 32'h0C || log_op[8] !== OP_PUT_FULL || log_data[8] !== 32'h0) begin
      miscompares++; $display("FAIL timeout_disable got addr %h op %0d data %h want %h 0 0", log_addr[8], log_op[8], log_data[8], BASE + 32'h0C); end
    vectors++; if (err_cnt !== 1) begin miscompares++; $display("FAIL timeout_err got %0d pulses want 1", err_cnt); end
    vectors++; if (sv_seen !== 1'b0) begin miscompares++; $display("FAIL timeout_valid got seen want never"); end
  endtask

  task automatic test_derror();
    bit ok;
    reset_dut();
    done_after = 0; dout_val = 24'h777777;
    err_en = 1; err_addr = BASE + 32'h14;
    pulse_start(4'h1);
    wait_idle(3000, ok);
    repeat (3) @(negedge clk);
    vectors++; if (ok !== 1'b1 || log_n !== 7) begin miscompares++; $display("FAIL derr_reqs got ok %b reqs %0d want 1 7", ok, log_n); end
    vectors++; if (log_addr[5] !== BASE + 32'h14 || log_addr[6] !== BASE + 32'h0C || log_op[6] !== OP_PUT_FULL || log_data[6] !== 32'h0) begin
      miscompares++; $display("FAIL derr_next got %h then %h data %h want %h then %h data 0",
                              log_addr[5], log_addr[6], log_data[6], BASE + 32'h14, BASE + 32'h0C); end
    vectors++; if (err_cnt !== 1) begin miscompares++; $display("FAIL derr_err got %0d pulses want 1", err_cnt); end
    vectors++; if (sv_seen !== 1'b0) begin miscompares++; $display("FAIL derr_valid got seen want never"); end
    err_en = 0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    reset_dut();
    done_after = 1000;
    pulse_start(4'h3);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus.tl_o.a_valid && bus.tl_o.a_address == BASE + 32'h18) begin found = 1; break; end
    end
    vectors++; if (found !== 1'b1) begin miscompares++; $display("FAIL rstmid_poll got timeout want poll request"); end
    rst = 1;
    @(posedge clk);
    #1;
    vectors++; if (bus.tl_o.a_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_abandon got a_valid %b busy %b want 0 0", bus.tl_o.a_valid, busy); end
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    log_n = 0;
    repeat (60) @(negedge clk);
    vectors++; if (log_n !== 0 || busy !== 1'b0) begin miscompares++; $display("FAIL rstmid_reissue got %0d reqs busy %b want 0 0", log_n, busy); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base_n;
    int low0;
    bit found = 0;
    reset_dut();
    done_after = 0; dout_val = 24'h0F0F0F;
    @(negedge clk);
    start = 1; conv_time = 4'h3;
    wait_sv(3000, ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL b2b_first got timeout want sample_valid"); end
    base_n = log_n;
    low0 = busy_low;
    ready = 1;
    @(posedge clk);
    #1;
`ifdef TEMPSENS_HOST_CONT_EN
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %b want 1", busy); end
`else
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_busy got %b want 0", busy); end
`endif
    @(negedge clk);
    ready = 0;
    for (int i = 0; i < 200; i++) begin
      if (log_n > base_n) begin found = 1; break; end
      @(negedge clk);
    end
    start = 0;
    vectors++; if (found !== 1'b1 || log_addr[base_n] !== BASE + 32'h04 || log_data[base_n] !== 32'h0 || log_op[base_n] !== OP_PUT_FULL) begin
      miscompares++; $display("FAIL b2b_next got found %b addr %h data %h want 1 %h 0", found, log_addr[base_n], log_data[base_n], BASE + 32'h04); end
`ifdef TEMPSENS_HOST_CONT_EN
    vectors++; if (busy_low - low0 !== 0) begin miscompares++; $display("FAIL b2b_gap got %0d idle cycles want 0", busy_low - low0); end
`else
    vectors++; if (busy_low - low0 < 1) begin miscompares++; $display("FAIL b2b_gap got %0d idle cycles want >=1", busy_low - low0); end
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got time limit want completion");
    $fatal(1);
  end

  initial begin
    rst = 1; start = 0; ready = 0; conv_time = 4'h0;
    log_n = 0; poll_seen = 0; err_cnt = 0; sv_seen = 0; busy_low = 0;
    err_en = 0; stall_left = 0; stall_addr = 32'h0; err_addr = 32'h0;
    done_after = 0; dout_val = 24'h0;
    test_reset();
    test_conversion();
    test_out_stall();
    test_a_stall();
    test_timeout();
    test_derror();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
